// File: rtl/host_output_schedule.sv
// host_output_schedule: read side of the host input queue.
// Drains TS descriptors from the 32-entry TS descriptor RAM (on scheduler request)
// and NTS descriptors from the NTS FIFO, presenting one at a time to the host output
// interface over valid/ready. Also owns the TS slot occupancy bitmap.
// Optional build macro HOST_OUTPUT_SCHEDULE_STAT_EN adds per-source accepted counters.
module host_output_schedule #(
    parameter int NTS_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ts_descriptor_wr,
    input  logic [4:0]  iv_ts_descriptor_waddr,
    output logic        o_ts_descriptor_rd,
    output logic [4:0]  ov_ts_descriptor_raddr,
    input  logic [12:0] iv_ts_descriptor_rdata,
    input  logic        i_ts_submit_req,
    input  logic [4:0]  iv_ts_submit_addr,
    input  logic        i_nts_fifo_empty,
    output logic        o_nts_fifo_rd,
    input  logic [12:0] iv_nts_fifo_rdata,
    output logic [31:0] ov_ts_cnt,
    output logic        o_desc_valid,
    input  logic        i_desc_ready,
    output logic [8:0]  ov_bufid,
    output logic [3:0]  ov_pkt_inport,
    output logic        o_desc_is_ts,
    output logic        o_free_bufid_wr,
    output logic [8:0]  ov_free_bufid,
    output logic        o_ts_underflow_error_pulse
`ifdef HOST_OUTPUT_SCHEDULE_STAT_EN
    ,
    output logic [15:0] ov_ts_out_cnt,
    output logic [15:0] ov_nts_out_cnt
`endif
);

    localparam int BW = $clog2(NTS_BURST + 1);

    typedef enum logic [1:0] {IDLE, TS_RD, NTS_RD, OUT} state_t;

    state_t         state_reg, state_next;
    logic [31:0]    occ_reg, occ_next;
    logic [31:0]    pending_reg, pending_next;
    logic [BW-1:0]  burst_reg, burst_next;
    logic           run_reg;
    logic           underflow_reg, underflow_next;

    logic           valid_reg;
    logic [8:0]     bufid_reg;
    logic [3:0]     inport_reg;
    logic           is_ts_reg;
    logic           free_wr_reg;
    logic [8:0]     free_bufid_reg;

    logic           ts_rd;
    logic           nts_rd;
    logic [4:0]     ts_idx;
    logic [31:0]    wr_hit, rd_hit, req_hit, req_ok;
    logic [12:0]    rd_data;
    logic           rd_is_free;

    // Per-slot decode of write snoop, read clear and scheduler request
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_slot
            assign wr_hit[gi]  = i_ts_descriptor_wr && (iv_ts_descriptor_waddr == 5'(gi));
            assign rd_hit[gi]  = ts_rd && (ts_idx == 5'(gi));
            assign req_hit[gi] = i_ts_submit_req && (iv_ts_submit_addr == 5'(gi));
            // a request is valid if the slot is occupied now or being written this cycle
            assign req_ok[gi]  = req_hit[gi] && (occ_reg[gi] || wr_hit[gi]);
        end
    endgenerate

    // Lowest pending slot index
    always_comb begin
        ts_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (pending_reg[i]) begin
                ts_idx = 5'(i);
            end
        end
    end

    // Occupancy / pending next-state: set beats clear on occupancy; pending slots absorb repeats
    always_comb begin
        occ_next       = (occ_reg & ~rd_hit) | wr_hit;
        pending_next   = (pending_reg & ~rd_hit) | (req_ok & ~pending_reg);
        underflow_next = i_ts_submit_req && !(|req_ok);
    end

    // Scheduler FSM next-state and read strobes
    always_comb begin
        state_next = state_reg;
        burst_next = burst_reg;
        ts_rd      = 1'b0;
        nts_rd     = 1'b0;
        case (state_reg)
            IDLE: begin
                // run_reg keeps the strobes low while reset is (or just was) asserted
                if (run_reg) begin
                    if (|pending_reg) begin
                        ts_rd      = 1'b1;
                        burst_next = '0;
                        state_next = TS_RD;
                    end else if (burst_reg == BW'(NTS_BURST)) begin
                        burst_next = '0;
                    end else if (!i_nts_fifo_empty) begin
                        nts_rd     = 1'b1;
                        burst_next = burst_reg + BW'(1);
                        state_next = NTS_RD;
                    end
                end
            end
            TS_RD, NTS_RD: begin
                state_next = rd_is_free ? IDLE : OUT;
            end
            OUT: begin
                if (i_desc_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_data    = (state_reg == TS_RD) ? iv_ts_descriptor_rdata : iv_nts_fifo_rdata;
    assign rd_is_free = (rd_data[12:9] == 4'hf);

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            occ_reg       <= '0;
            pending_reg   <= '0;
            burst_reg     <= '0;
            run_reg       <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            occ_reg       <= occ_next;
            pending_reg   <= pending_next;
            burst_reg     <= burst_next;
            run_reg       <= 1'b1;
            underflow_reg <= underflow_next;
        end
    end

    // Output descriptor and free-request registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_reg      <= 1'b0;
            bufid_reg      <= '0;
            inport_reg     <= '0;
            is_ts_reg      <= 1'b0;
            free_wr_reg    <= 1'b0;
            free_bufid_reg <= '0;
        end else begin
            free_wr_reg <= 1'b0;
            if (state_reg == TS_RD || state_reg == NTS_RD) begin
                if (rd_is_free) begin
                    free_wr_reg    <= 1'b1;
                    free_bufid_reg <= rd_data[8:0];
                end else begin
                    valid_reg  <= 1'b1;
                    bufid_reg  <= rd_data[8:0];
                    inport_reg <= rd_data[12:9];
                    is_ts_reg  <= (state_reg == TS_RD);
                end
            end else if (state_reg == OUT && i_desc_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

`ifdef HOST_OUTPUT_SCHEDULE_STAT_EN
    logic [15:0] ts_out_cnt_reg, nts_out_cnt_reg;

    // Accepted-handshake counters per source, free-running with wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_out_cnt_reg  <= '0;
            nts_out_cnt_reg <= '0;
        end else if (valid_reg && i_desc_ready) begin
            if (is_ts_reg) begin
                ts_out_cnt_reg <= ts_out_cnt_reg + 16'd1;
            end else begin
                nts_out_cnt_reg <= nts_out_cnt_reg + 16'd1;
            end
        end
    end

    assign ov_ts_out_cnt  = ts_out_cnt_reg;
    assign ov_nts_out_cnt = nts_out_cnt_reg;
`endif

    assign o_ts_descriptor_rd         = ts_rd;
    assign ov_ts_descriptor_raddr     = ts_rd ? ts_idx : 5'd0;
    assign o_nts_fifo_rd              = nts_rd;
    assign ov_ts_cnt                  = occ_reg;
    assign o_desc_valid               = valid_reg;
    assign ov_bufid                   = bufid_reg;
    assign ov_pkt_inport              = inport_reg;
    assign o_desc_is_ts               = is_ts_reg;
    assign o_free_bufid_wr            = free_wr_reg;
    assign ov_free_bufid              = free_bufid_reg;
    assign o_ts_underflow_error_pulse = underflow_reg;

endmodule

// File: tb/tb_host_output_schedule.sv
// Testbench for host_output_schedule: randomized scoreboard bench with TS RAM / NTS FIFO models.
`timescale 1ns/1ps
module tb_host_output_schedule;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_ts_descriptor_wr;
    logic [4:0]  iv_ts_descriptor_waddr;
    logic        o_ts_descriptor_rd;
    logic [4:0]  ov_ts_descriptor_raddr;
    logic [12:0] iv_ts_descriptor_rdata;
    logic        i_ts_submit_req;
    logic [4:0]  iv_ts_submit_addr;
    logic        i_nts_fifo_empty;
    logic        o_nts_fifo_rd;
    logic [12:0] iv_nts_fifo_rdata;
    logic [31:0] ov_ts_cnt;
    logic        o_desc_valid;
    logic        i_desc_ready;
    logic [8:0]  ov_bufid;
    logic [3:0]  ov_pkt_inport;
    logic        o_desc_is_ts;
    logic        o_free_bufid_wr;
    logic [8:0]  ov_free_bufid;
    logic        o_ts_underflow_error_pulse;
`ifdef HOST_OUTPUT_SCHEDULE_STAT_EN
    logic [15:0] ov_ts_out_cnt;
    logic [15:0] ov_nts_out_cnt;
`endif

    host_output_schedule dut (
        .i_clk                     (i_clk),
        .i_rst_n                   (i_rst_n),
        .i_ts_descriptor_wr        (i_ts_descriptor_wr),
        .iv_ts_descriptor_waddr    (iv_ts_descriptor_waddr),
        .o_ts_descriptor_rd        (o_ts_descriptor_rd),
        .ov_ts_descriptor_raddr    (ov_ts_descriptor_raddr),
        .iv_ts_descriptor_rdata    (iv_ts_descriptor_rdata),
        .i_ts_submit_req           (i_ts_submit_req),
        .iv_ts_submit_addr         (iv_ts_submit_addr),
        .i_nts_fifo_empty          (i_nts_fifo_empty),
        .o_nts_fifo_rd             (o_nts_fifo_rd),
        .iv_nts_fifo_rdata         (iv_nts_fifo_rdata),
        .ov_ts_cnt                 (ov_ts_cnt),
        .o_desc_valid              (o_desc_valid),
        .i_desc_ready              (i_desc_ready),
        .ov_bufid                  (ov_bufid),
        .ov_pkt_inport             (ov_pkt_inport),
        .o_desc_is_ts              (o_desc_is_ts),
        .o_free_bufid_wr           (o_free_bufid_wr),
        .ov_free_bufid             (ov_free_bufid),
        .o_ts_underflow_error_pulse(o_ts_underflow_error_pulse)
`ifdef HOST_OUTPUT_SCHEDULE_STAT_EN
        ,
        .ov_ts_out_cnt             (ov_ts_out_cnt),
        .ov_nts_out_cnt            (ov_nts_out_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] exp_desc[$];     // {is_ts, inport, bufid} in expected issue order
    logic [8:0]  exp_free[$];     // expected free-request bufids in order
    logic [12:0] nts_q[$];        // NTS FIFO contents
    logic [12:0] ram[32];         // TS descriptor RAM contents
    int          cycle       = 0;
    int          err_cycles  = 0;
    int          ts_rd_count = 0;
    int          hs_count    = 0;
    int          hs_ts       = 0;
    int          hs_nts      = 0;
    int          rd_cycles[$];
    logic        ready_rand  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_nts(input logic [12:0] d);
        nts_q.push_back(d);
        i_nts_fifo_empty = 1'b0;
    endtask

    task automatic ts_write(input logic [4:0] a, input logic [12:0] d);
        tick();
        i_ts_descriptor_wr     = 1'b1;
        iv_ts_descriptor_waddr = a;
        ram[a]                 = d;
        tick();
        i_ts_descriptor_wr     = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!o_desc_valid && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, o_desc_valid}, 32'd1);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((exp_desc.size() != 0 || exp_free.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, exp_desc.size() + exp_free.size(), 0);
        exp_desc.delete();
        exp_free.delete();
        repeat (3) tick();
    endtask

    function automatic logic [12:0] rand_desc(input logic allow_free);
        logic [3:0] ip;
        logic [8:0] b;
        ip = allow_free ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 14));
        b  = 9'($urandom);
        return {ip, b};
    endfunction

    function automatic logic [12:0] rand_desc_biased();
        logic [12:0] d;
        d = rand_desc(1'b0);
        if ($urandom_range(0, 4) == 0) d[12:9] = 4'hf;
        return d;
    endfunction

    // Memory models: TS RAM and NTS FIFO both return data one cycle after the strobe
    initial begin
        logic       trd, nrd;
        logic [4:0] ta;
        forever begin
            @(negedge i_clk);
            trd = o_ts_descriptor_rd;
            ta  = ov_ts_descriptor_raddr;
            nrd = o_nts_fifo_rd;
            @(posedge i_clk);
            #1;
            if (trd) iv_ts_descriptor_rdata = ram[ta];
            if (nrd && nts_q.size() > 0) iv_nts_fifo_rdata = nts_q.pop_front();
            i_nts_fifo_empty = (nts_q.size() == 0);
        end
    end

    // Monitor: pops the scoreboard on each handshake / free pulse and checks hold stability
    initial begin
        logic        held;
        logic [13:0] held_data, cur, e;
        logic [8:0]  ef;
        held = 1'b0;
        forever begin
            @(negedge i_clk);
            cycle++;
            if (!i_rst_n) begin
                held   = 1'b0;
                hs_ts  = 0;
                hs_nts = 0;
                continue;
            end
            cur = {o_desc_is_ts, ov_pkt_inport, ov_bufid};
            if (o_nts_fifo_rd) begin
                rd_cycles.push_back(cycle);
                chk("fifo_rd_when_empty", {31'd0, i_nts_fifo_empty}, 32'd0);
            end
            if (o_ts_descriptor_rd) ts_rd_count++;
            if (o_ts_underflow_error_pulse) err_cycles++;
            if (o_free_bufid_wr) begin
                if (exp_free.size() == 0) begin
                    unexpected("free_pulse", {23'd0, ov_free_bufid});
                end else begin
                    ef = exp_free.pop_front();
                    chk("free_bufid", {23'd0, ov_free_bufid}, {23'd0, ef});
                    $display("[TB] free bufid=%h", ov_free_bufid);
                end
            end
            if (held) begin
                chk("hold_valid", {31'd0, o_desc_valid}, 32'd1);
                if (o_desc_valid) chk("hold_data", {18'd0, cur}, {18'd0, held_data});
            end
            held = 1'b0;
            if (o_desc_valid) begin
                if (i_desc_ready) begin
                    hs_count++;
                    if (o_desc_is_ts) hs_ts++;
                    else hs_nts++;
                    if (exp_desc.size() == 0) begin
                        unexpected("desc_handshake", {18'd0, cur});
                    end else begin
                        e = exp_desc.pop_front();
                        chk("desc", {18'd0, cur}, {18'd0, e});
                        $display("[TB] desc ts=%0d inport=%h bufid=%h", o_desc_is_ts, ov_pkt_inport, ov_bufid);
                    end
                end else begin
                    held      = 1'b1;
                    held_data = cur;
                end
            end
        end
    end

    // Random backpressure driver when enabled
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (ready_rand) i_desc_ready = 1'($urandom_range(0, 1));
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // One TS round: occupy slots, hold an NTS descriptor in OUT, submit, then release
    task automatic ts_round(input logic directed);
        logic [31:0] mask;
        logic [12:0] data_s[32];
        logic [12:0] a, b, c;
        int          subs[$];
        int          n_under, e0, tmp, j, s;
        mask    = '0;
        n_under = 0;
        for (int k = 0; k < 32; k++) begin
            if (directed) mask[k] = (k == 3 || k == 9);
            else mask[k] = ($urandom_range(0, 2) == 0);
        end
        for (int k = 0; k < 32; k++) begin
            if (mask[k]) begin
                data_s[k] = directed ? rand_desc(1'b0) : rand_desc_biased();
                ts_write(5'(k), data_s[k]);
            end
        end
        chk("ts_cnt_after_writes", ov_ts_cnt, mask);
        ready_rand   = 1'b0;
        i_desc_ready = 1'b0;
        a = rand_desc(1'b0);
        b = rand_desc(1'b0);
        c = rand_desc(1'b0);
        push_nts(a);
        exp_desc.push_back({1'b0, a});
        wait_valid(20, "round_hold_valid");
        if (directed) begin
            subs.push_back(9);
            subs.push_back(3);
        end else begin
            for (int k = 0; k < 32; k++) if (mask[k]) subs.push_back(k);
            for (int k = subs.size() - 1; k > 0; k--) begin
                j       = $urandom_range(0, k);
                tmp     = subs[k];
                subs[k] = subs[j];
                subs[j] = tmp;
            end
            if (subs.size() > 0) subs.push_back(subs[0]);
            for (int k = 0; k < 2; k++) begin
                s = $urandom_range(0, 31);
                if (!mask[s] && $urandom_range(0, 1) == 1) begin
                    subs.push_back(s);
                    n_under++;
                end
            end
        end
        e0 = err_cycles;
        foreach (subs[k]) begin
            tick();
            i_ts_submit_req   = 1'b1;
            iv_ts_submit_addr = 5'(subs[k]);
        end
        tick();
        i_ts_submit_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (mask[k]) begin
                if (data_s[k][12:9] == 4'hf) exp_free.push_back(data_s[k][8:0]);
                else exp_desc.push_back({1'b1, data_s[k]});
            end
        end
        push_nts(b);
        push_nts(c);
        exp_desc.push_back({1'b0, b});
        exp_desc.push_back({1'b0, c});
        ready_rand = 1'b1;
        drain(600, "ts_round");
        chk("round_underflow_count", err_cycles - e0, n_under);
        chk("round_ts_cnt_empty", ov_ts_cnt, 32'd0);
    endtask

    initial begin
        int          exp_gap[5];
        int          e0, n0, h0;
        logic [12:0] d;
        exp_gap = '{3, 3, 3, 4, 3};

        i_rst_n = 1'b1;
        i_ts_descriptor_wr = 1'b0;
        iv_ts_descriptor_waddr = '0;
        iv_ts_descriptor_rdata = '0;
        i_ts_submit_req = 1'b0;
        iv_ts_submit_addr = '0;
        i_nts_fifo_empty = 1'b1;
        iv_nts_fifo_rdata = '0;
        i_desc_ready = 1'b0;
        for (int k = 0; k < 32; k++) ram[k] = '0;

        // Reset state
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, o_desc_valid}, 32'd0);
        chk("rst_ts_cnt", ov_ts_cnt, 32'd0);
        chk("rst_strobes", {29'd0, o_ts_descriptor_rd, o_nts_fifo_rd, o_free_bufid_wr}, 32'd0);
        chk("rst_data", {13'd0, o_desc_is_ts, ov_pkt_inport, ov_bufid, o_ts_underflow_error_pulse}, 32'd0);
        repeat (3) tick();
        i_rst_n = 1'b1;
        repeat (2) tick();

        // NTS burst: six descriptors with ready held high
        i_desc_ready = 1'b1;
        rd_cycles.delete();
        for (int k = 0; k < 6; k++) begin
            d = rand_desc(1'b0);
            push_nts(d);
            exp_desc.push_back({1'b0, d});
        end
        drain(100, "burst");
        chk("burst_reads", rd_cycles.size(), 6);
        if (rd_cycles.size() == 6) begin
            for (int k = 0; k < 5; k++) chk("burst_gap", rd_cycles[k+1] - rd_cycles[k], exp_gap[k]);
        end

        // Single TS descriptor from slot 5
        ts_write(5'd5, {4'h2, 9'h01A});
        chk("slot5_occupied", {31'd0, ov_ts_cnt[5]}, 32'd1);
        exp_desc.push_back({1'b1, 4'h2, 9'h01A});
        i_ts_submit_req   = 1'b1;
        iv_ts_submit_addr = 5'd5;
        tick();
        i_ts_submit_req = 1'b0;
        chk("slot5_rd", {26'd0, o_ts_descriptor_rd, ov_ts_descriptor_raddr}, {26'd0, 1'b1, 5'd5});
        tick();
        chk("slot5_cleared", {31'd0, ov_ts_cnt[5]}, 32'd0);
        chk("slot5_not_yet_valid", {31'd0, o_desc_valid}, 32'd0);
        tick();
        chk("slot5_valid", {18'd0, o_desc_valid, ov_pkt_inport, ov_bufid}, {18'd0, 1'b1, 4'h2, 9'h01A});
        drain(20, "slot5");

        // Request for an empty slot
        e0 = err_cycles;
        n0 = ts_rd_count;
        i_ts_submit_req   = 1'b1;
        iv_ts_submit_addr = 5'd7;
        tick();
        i_ts_submit_req = 1'b0;
        chk("underflow_pulse", {31'd0, o_ts_underflow_error_pulse}, 32'd1);
        tick();
        chk("underflow_pulse_end", {31'd0, o_ts_underflow_error_pulse}, 32'd0);
        repeat (3) tick();
        chk("underflow_cycles", err_cycles - e0, 1);
        chk("underflow_no_read", ts_rd_count - n0, 0);

        // NTS entry with inport 0xf becomes a free request
        h0 = hs_count;
        push_nts({4'hf, 9'h0C3});
        exp_free.push_back(9'h0C3);
        drain(20, "free");
        chk("free_no_valid", hs_count - h0, 0);

        // Write and clear of slot 12 in the same cycle
        d = rand_desc(1'b0);
        ts_write(5'd12, d);
        exp_desc.push_back({1'b1, d});
        i_ts_submit_req   = 1'b1;
        iv_ts_submit_addr = 5'd12;
        tick();
        i_ts_submit_req        = 1'b0;
        i_ts_descriptor_wr     = 1'b1;
        iv_ts_descriptor_waddr = 5'd12;
        chk("slot12_rd", {26'd0, o_ts_descriptor_rd, ov_ts_descriptor_raddr}, {26'd0, 1'b1, 5'd12});
        tick();
        i_ts_descriptor_wr = 1'b0;
        chk("slot12_set_wins", {31'd0, ov_ts_cnt[12]}, 32'd1);
        drain(20, "slot12_first");
        exp_desc.push_back({1'b1, d});
        i_ts_submit_req   = 1'b1;
        iv_ts_submit_addr = 5'd12;
        tick();
        i_ts_submit_req = 1'b0;
        drain(20, "slot12_second");
        chk("slot12_empty", ov_ts_cnt, 32'd0);

        // TS priority rounds: directed slots 3/9, then randomized
        ts_round(1'b1);
        for (int r = 0; r < 3; r++) ts_round(1'b0);

        // Random NTS stream with random backpressure
        ready_rand = 1'b1;
        for (int k = 0; k < 24; k++) begin
            d = rand_desc_biased();
            push_nts(d);
            if (d[12:9] == 4'hf) exp_free.push_back(d[8:0]);
            else exp_desc.push_back({1'b0, d});
        end
        drain(600, "nts_stream");

        // Reset while a descriptor is held in OUT
        ready_rand   = 1'b0;
        i_desc_ready = 1'b0;
        ts_write(5'd20, rand_desc(1'b0));
        chk("slot20_occupied", {31'd0, ov_ts_cnt[20]}, 32'd1);
        d = rand_desc(1'b0);
        push_nts(d);
        exp_desc.push_back({1'b0, d});
        wait_valid(20, "pre_reset_valid");
        tick();
        i_rst_n = 1'b0;
        exp_desc.delete();
        #1;
        chk("midrst_valid", {31'd0, o_desc_valid}, 32'd0);
        chk("midrst_ts_cnt", ov_ts_cnt, 32'd0);
        chk("midrst_data", {13'd0, o_desc_is_ts, ov_pkt_inport, ov_bufid, o_ts_underflow_error_pulse}, 32'd0);
        chk("midrst_strobes", {29'd0, o_ts_descriptor_rd, o_nts_fifo_rd, o_free_bufid_wr}, 32'd0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        repeat (2) tick();

        // After reset: NTS still flows, old TS slot is forgotten
        ready_rand = 1'b1;
        d = rand_desc(1'b0);
        push_nts(d);
        exp_desc.push_back({1'b0, d});
        drain(40, "post_reset");
        e0 = err_cycles;
        i_ts_submit_req   = 1'b1;
        iv_ts_submit_addr = 5'd20;
        tick();
        i_ts_submit_req = 1'b0;
        repeat (3) tick();
        chk("post_reset_slot20_underflow", err_cycles - e0, 1);

`ifdef HOST_OUTPUT_SCHEDULE_STAT_EN
        chk("stat_ts", {16'd0, ov_ts_out_cnt}, 32'(hs_ts));
        chk("stat_nts", {16'd0, ov_nts_out_cnt}, 32'(hs_nts));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/host_output_schedule.md
Name: host_output_schedule

Overview:
- Read side of the host input queue: drains TS descriptors from the 32-entry TS descriptor RAM and NTS descriptors from the NTS descriptor FIFO.
- Presents one descriptor at a time to the host output interface using a valid/ready handshake.
- Owns the 32-bit TS slot occupancy bitmap that the input queue uses as its overflow check.
- Sits between host_input_queue / descriptor storage and the host output interface (HOI).

Parameters:
- NTS_BURST, 4, maximum consecutive NTS descriptors issued while no TS request is pending (fairness bound is trivially met; the counter resets on every TS issue).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ts_descriptor_wr  in  1  snoop of TS RAM write strobe
- iv_ts_descriptor_waddr  in  5  snoop of TS RAM write address
- o_ts_descriptor_rd  out  1  TS RAM read strobe
- ov_ts_descriptor_raddr  out  5  TS RAM read address
- iv_ts_descriptor_rdata  in  13  {inport[3:0], bufid[8:0]}; valid 1 cycle after rd
- i_ts_submit_req  in  1  scheduler: TS slot due
- iv_ts_submit_addr  in  5  slot index of the request
- i_nts_fifo_empty  in  1  NTS FIFO empty
- o_nts_fifo_rd  out  1  NTS FIFO read strobe
- iv_nts_fifo_rdata  in  13  {inport, bufid}; valid 1 cycle after rd
- ov_ts_cnt  out  32  slot occupancy bitmap
- o_desc_valid  out  1  descriptor valid to HOI
- i_desc_ready  in  1  HOI accepts
- ov_bufid  out  9  descriptor bufid
- ov_pkt_inport  out  4  descriptor inport
- o_desc_is_ts  out  1  descriptor came from the TS RAM
- o_free_bufid_wr  out  1  free-request pulse
- ov_free_bufid  out  9  bufid to free
- o_ts_underflow_error_pulse  out  1  request for an empty slot

Behaviour:
- Reset: all outputs 0; ov_ts_cnt=0; pending register=0; FSM in IDLE; burst counter=0.

Occupancy bitmap:
- Set bit waddr when i_ts_descriptor_wr=1.
- Clear bit raddr on the cycle o_ts_descriptor_rd=1.
- Same bit set and cleared in the same cycle: set wins.

Pending register (32 bits):
- i_ts_submit_req with the occupancy bit set (or being set this cycle): set pending[addr].
- i_ts_submit_req with the occupancy bit clear: pending unchanged; o_ts_underflow_error_pulse=1 for 1 cycle (registered).
- A request for an already-pending slot is absorbed, with no error.

FSM states: IDLE, TS_RD, NTS_RD, OUT.
- IDLE, any pending bit set:
  - Pick the lowest index p.
  - Assert o_ts_descriptor_rd=1 and raddr=p for one cycle.
  - Clear pending[p] and occupancy[p]; reset burst counter.
  - Go to TS_RD.
- IDLE, no pending bits, !i_nts_fifo_empty, and burst counter < NTS_BURST:
  - Assert o_nts_fifo_rd=1 for one cycle; increment burst counter.
  - Go to NTS_RD.
- IDLE, no pending bits, burst counter = NTS_BURST: stay one idle cycle, reset the counter, then resume.
- TS_RD / NTS_RD: capture rdata.
  - inport==4'hf: set o_free_bufid_wr=1 and ov_free_bufid=bufid for 1 cycle, no valid, return to IDLE.
  - Otherwise: load ov_bufid, ov_pkt_inport, o_desc_is_ts; set o_desc_valid=1; go to OUT.
- OUT: hold the data and o_desc_valid stable until i_desc_ready=1. The cycle after acceptance, o_desc_valid=0 and the FSM is in IDLE.
- Throughput: read strobe to valid is 2 cycles. With i_desc_ready constantly 1, one descriptor is issued every 3 cycles.
- Reads only ever start from IDLE, so at most one read is in flight; the FIFO is never read when empty.
- TS requests arriving during TS_RD/NTS_RD/OUT are latched in pending and served on the next IDLE. A TS request never preempts a descriptor held in OUT.
- Reset mid-operation: all state is discarded; an in-flight descriptor is lost, with no free pulse.

Optional Feature:
- HOST_OUTPUT_SCHEDULE_STAT_EN defined: adds outputs ov_ts_out_cnt[15:0] and ov_nts_out_cnt[15:0].
  - Each counts accepted handshakes by source (o_desc_is_ts).
  - Counters wrap at 16'hFFFF→0 and reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write slot 5 (data {4'h2,9'h01A}), then submit_req addr 5 → ov_ts_cnt[5] set then cleared at the rd strobe; raddr=5; two cycles later o_desc_valid=1, bufid=0x01A, inport=2, is_ts=1.
- submit_req addr 7 with ov_ts_cnt=0 → o_ts_underflow_error_pulse for exactly 1 cycle; no RAM read.
- NTS FIFO holds 6 descriptors, ready=1, no TS traffic → 4 FIFO reads, one idle cycle, then the remaining 2; fifo_rd never asserted while empty.
- NTS entry {4'hf,9'h0C3} → o_free_bufid_wr pulse with ov_free_bufid=0x0C3; o_desc_valid stays 0.
- Slots 3 and 9 occupied; submit 9 then 3 while an NTS descriptor is held with ready=0 → after ready, slot 3 is served before 9, and both before any further NTS.
- Write and clear of slot 12 in the same cycle → ov_ts_cnt[12]=1 afterwards; reset asserted in OUT → all outputs 0 in the same cycle.
